// File: rtl/ulpi_reg_ctl.sv
// rtl/ulpi_reg_ctl.sv - ULPI PHY register read/write controller with abort retry and RX CMD capture
module ulpi_reg_ctl #(
   parameter int unsigned MAX_RETRY = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ulpi_dir,
   input  logic       ulpi_nxt,
   input  logic [7:0] ulpi_rx_data,
   output logic [7:0] ulpi_tx_data,
   output logic       ulpi_stp,
   input  logic       reg_req,
   input  logic       reg_we,
   input  logic [5:0] reg_addr,
   input  logic [7:0] reg_wdata,
   output logic       reg_ack,
   output logic       reg_err,
   output logic [7:0] reg_rdata,
   output logic [7:0] rx_cmd,
   output logic       rx_cmd_valid
);

   // The count only ever holds 0..MAX_RETRY-1: reaching MAX_RETRY completes the request and clears it.
   localparam int unsigned RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      WDATA,
      STP,
      RD_TURN,
      RD_DATA
   } state_t;

   state_t          state_q, state_d;
   logic            dir_q;
   logic            we_q, we_d;
   logic [5:0]      addr_q, addr_d;
   logic [7:0]      wdata_q, wdata_d;
   logic [RW-1:0]   retry_q, retry_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            stp_q, stp_d;
   logic            ack_q, ack_d;
   logic            err_q, err_d;
   logic [7:0]      rdata_q, rdata_d;
   logic [7:0]      rx_cmd_q, rx_cmd_d;
   logic            rx_cmd_valid_q, rx_cmd_valid_d;

   logic            turnaround;
   logic            abort;
   logic            rx_hit;

   // A cycle where the PHY flips dir relative to last cycle carries no usable bus data.
   assign turnaround = (ulpi_dir != dir_q);

   // Next-state, request latching, retry bookkeeping and completion generation.
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      retry_d = retry_q;
      ack_d   = 1'b0;
      err_d   = err_q;
      rdata_d = rdata_q;
      abort   = 1'b0;

      case (state_q)
         IDLE: begin
            // Only start on a settled, link-owned bus (dir low now and last cycle).
            if (reg_req && !ulpi_dir && !turnaround) begin
               state_d = CMD;
               we_d    = reg_we;
               addr_d  = reg_addr;
               wdata_d = reg_wdata;
            end
         end
         CMD: begin
            if (ulpi_dir) begin
               abort = 1'b1;
            end else if (ulpi_nxt) begin
               state_d = we_q ? WDATA : RD_TURN;
            end
         end
         WDATA: begin
            if (ulpi_dir) begin
               abort = 1'b1;
            end else if (ulpi_nxt) begin
               state_d = STP;
            end
         end
         STP: begin
            state_d = IDLE;
            ack_d   = 1'b1;
            err_d   = 1'b0;
            retry_d = '0;
         end
         RD_TURN: begin
            // dir with nxt means the PHY took the bus for received data, not our read.
            if (ulpi_dir && ulpi_nxt) begin
               abort = 1'b1;
            end else if (ulpi_dir) begin
               state_d = RD_DATA;
            end
         end
         RD_DATA: begin
            state_d = IDLE;
            rdata_d = ulpi_rx_data;
            ack_d   = 1'b1;
            err_d   = 1'b0;
            retry_d = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // An abort drops back to IDLE; the still-held request re-issues from there
      // unless this abort exhausts the retry budget.
      if (abort) begin
         state_d = IDLE;
         if (retry_q == RW'(MAX_RETRY - 1)) begin
            ack_d   = 1'b1;
            err_d   = 1'b1;
            retry_d = '0;
         end else begin
            retry_d = retry_q + RW'(1);
         end
      end
   end

   // Bus output decode from the upcoming state so the pins are driven straight from flops.
   always_comb begin
      tx_data_d = 8'h00;
      stp_d     = 1'b0;
      case (state_d)
         CMD:     tx_data_d = we_d ? {2'b10, addr_d} : {2'b11, addr_d};
         WDATA:   tx_data_d = wdata_d;
         STP:     stp_d     = 1'b1;
         default: tx_data_d = 8'h00;
      endcase
   end

   // RX CMD capture: PHY owns a settled bus, is not streaming data, and it is not our read byte.
   always_comb begin
      rx_hit         = ulpi_dir && !turnaround && !ulpi_nxt && (state_q != RD_DATA);
      rx_cmd_d       = rx_hit ? ulpi_rx_data : rx_cmd_q;
      rx_cmd_valid_d = rx_hit;
   end

   // State and output registers; reset discards any request in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         dir_q          <= 1'b0;
         we_q           <= 1'b0;
         addr_q         <= 6'h00;
         wdata_q        <= 8'h00;
         retry_q        <= '0;
         tx_data_q      <= 8'h00;
         stp_q          <= 1'b0;
         ack_q          <= 1'b0;
         err_q          <= 1'b0;
         rdata_q        <= 8'h00;
         rx_cmd_q       <= 8'h00;
         rx_cmd_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         dir_q          <= ulpi_dir;
         we_q           <= we_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         retry_q        <= retry_d;
         tx_data_q      <= tx_data_d;
         stp_q          <= stp_d;
         ack_q          <= ack_d;
         err_q          <= err_d;
         rdata_q        <= rdata_d;
         rx_cmd_q       <= rx_cmd_d;
         rx_cmd_valid_q <= rx_cmd_valid_d;
      end
   end

   assign ulpi_tx_data = tx_data_q;
   assign ulpi_stp     = stp_q;
   assign reg_ack      = ack_q;
   assign reg_err      = err_q;
   assign reg_rdata    = rdata_q;
   assign rx_cmd       = rx_cmd_q;
   assign rx_cmd_valid = rx_cmd_valid_q;

endmodule

// File: tb/tb_ulpi_reg_ctl.sv
// tb/tb_ulpi_reg_ctl.sv - scoreboard testbench for ulpi_reg_ctl with a scripted PHY
module tb_ulpi_reg_ctl;
   localparam int MR = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       ulpi_dir;
   logic       ulpi_nxt;
   logic [7:0] ulpi_rx_data;
   logic [7:0] ulpi_tx_data;
   logic       ulpi_stp;
   logic       reg_req;
   logic       reg_we;
   logic [5:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_ack;
   logic       reg_err;
   logic [7:0] reg_rdata;
   logic [7:0] rx_cmd;
   logic       rx_cmd_valid;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic       err;
      logic       is_read;
      logic [7:0] rdata;
      int         start;
      int         lat;
   } reg_exp_t;

   reg_exp_t   reg_q[$];
   logic [7:0] rx_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ulpi_reg_ctl #(.MAX_RETRY(MR)) dut (
      .clk          (clk),
      .rst          (rst),
      .ulpi_dir     (ulpi_dir),
      .ulpi_nxt     (ulpi_nxt),
      .ulpi_rx_data (ulpi_rx_data),
      .ulpi_tx_data (ulpi_tx_data),
      .ulpi_stp     (ulpi_stp),
      .reg_req      (reg_req),
      .reg_we       (reg_we),
      .reg_addr     (reg_addr),
      .reg_wdata    (reg_wdata),
      .reg_ack      (reg_ack),
      .reg_err      (reg_err),
      .reg_rdata    (reg_rdata),
      .rx_cmd       (rx_cmd),
      .rx_cmd_valid (rx_cmd_valid)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Monitor: pops the scoreboard whenever the DUT reports a completion or an RX CMD.
   always @(negedge clk) begin : monitor
      reg_exp_t e;
      if (rst === 1'b1) begin
         if (reg_ack === 1'b1) begin
            if (reg_q.size() == 0) begin
               check("unexpected_reg_ack", 32'(reg_ack), 32'd0);
            end else begin
               e = reg_q.pop_front();
               check("reg_err", 32'(reg_err), 32'(e.err));
               if (e.is_read && !e.err) check("reg_rdata", 32'(reg_rdata), 32'(e.rdata));
               if (e.lat >= 0) check("ack_latency", 32'(cyc - e.start), 32'(e.lat));
            end
         end
         if (rx_cmd_valid === 1'b1) begin
            if (rx_q.size() == 0) check("unexpected_rx_cmd", 32'(rx_cmd_valid), 32'd0);
            else check("rx_cmd", 32'(rx_cmd), 32'(rx_q.pop_front()));
         end
      end
   end

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         check("idle_tx_data", 32'(ulpi_tx_data), 32'd0);
         check("idle_stp", 32'(ulpi_stp), 32'd0);
      end
   endtask

   task automatic wait_cmd(input logic [7:0] cmd, input int exp_ticks);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (ulpi_tx_data !== cmd && n < 8);
      if (ulpi_tx_data !== cmd) begin
         checks++;
         errors++;
         $display("FAIL cmd_timeout: tx_data 0x%0h, expected 0x%0h", ulpi_tx_data, cmd);
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $fatal(1, "command byte never appeared");
      end
      check("cmd_start_cycles", 32'(n), 32'(exp_ticks));
   endtask

   // PHY grabs the bus mid-transaction, optionally lingering to send RX CMDs.
   task automatic phy_abort(input bit in_turn, input bit last);
      int h;
      ulpi_dir     = 1'b1;
      ulpi_nxt     = in_turn ? 1'b1 : 1'($urandom_range(0, 1));
      ulpi_rx_data = 8'($urandom);
      tick();
      check("abort_tx_data", 32'(ulpi_tx_data), 32'd0);
      check("abort_stp", 32'(ulpi_stp), 32'd0);
      if (last) reg_req = 1'b0;
      h = $urandom_range(0, 2);
      for (int i = 0; i < h; i++) begin
         ulpi_nxt     = 1'b0;
         ulpi_rx_data = 8'($urandom);
         rx_q.push_back(ulpi_rx_data);
         tick();
         check("abort_hold_tx", 32'(ulpi_tx_data), 32'd0);
      end
      ulpi_dir = 1'b0;
      ulpi_nxt = 1'b0;
   endtask

   // One register request: the first n_abort attempts are aborted by the PHY;
   // MR or more aborts means the request completes with error after MR attempts.
   task automatic do_req(input bit we, input logic [5:0] addr, input logic [7:0] wdata,
                         input logic [7:0] rdval, input int n_abort, input int dmax,
                         input int ph_sel);
      reg_exp_t   e;
      logic [7:0] cmd;
      bit         fail_req;
      bit         do_abort;
      bit         last;
      int         attempts;
      int         d1;
      int         d2;
      int         ph;
      cmd      = we ? (8'h80 | {2'b00, addr}) : (8'hC0 | {2'b00, addr});
      fail_req = (n_abort >= MR);
      attempts = fail_req ? MR : n_abort + 1;
      d1       = $urandom_range(0, dmax);
      d2       = $urandom_range(0, dmax);
      e.err     = fail_req;
      e.is_read = !we;
      e.rdata   = rdval;
      e.start   = cyc;
      e.lat     = (n_abort == 0) ? 4 + d1 + d2 : -1;
      reg_q.push_back(e);
      reg_req   = 1'b1;
      reg_we    = we;
      reg_addr  = addr;
      reg_wdata = wdata;
      for (int a = 0; a < attempts; a++) begin
         do_abort = fail_req || (a < n_abort);
         last     = fail_req && (a == attempts - 1);
         ph       = (ph_sel >= 0) ? ph_sel : $urandom_range(0, 1);
         if (a > 0) begin
            d1 = $urandom_range(0, dmax);
            d2 = $urandom_range(0, dmax);
         end
         wait_cmd(cmd, (a == 0) ? 1 : 2);
         if (do_abort && ph == 0) begin
            phy_abort(1'b0, last);
         end else begin
            for (int i = 0; i < d1; i++) begin
               tick();
               check("cmd_hold", 32'(ulpi_tx_data), 32'(cmd));
            end
            ulpi_nxt = 1'b1;
            tick();
            ulpi_nxt = 1'b0;
            if (we) begin
               check("wdata_byte", 32'(ulpi_tx_data), 32'(wdata));
               if (do_abort) begin
                  phy_abort(1'b0, last);
               end else begin
                  for (int i = 0; i < d2; i++) begin
                     tick();
                     check("wdata_hold", 32'(ulpi_tx_data), 32'(wdata));
                  end
                  ulpi_nxt = 1'b1;
                  tick();
                  ulpi_nxt = 1'b0;
                  check("stp_high", 32'(ulpi_stp), 32'd1);
                  check("stp_tx_data", 32'(ulpi_tx_data), 32'd0);
                  tick();
                  check("stp_one_cycle", 32'(ulpi_stp), 32'd0);
                  reg_req = 1'b0;
               end
            end else begin
               check("turn_tx_data", 32'(ulpi_tx_data), 32'd0);
               if (do_abort) begin
                  phy_abort(1'b1, last);
               end else begin
                  for (int i = 0; i < d2; i++) begin
                     tick();
                     check("turn_hold_tx", 32'(ulpi_tx_data), 32'd0);
                  end
                  ulpi_dir = 1'b1;
                  tick();
                  ulpi_rx_data = rdval;
                  tick();
                  ulpi_dir = 1'b0;
                  reg_req  = 1'b0;
               end
            end
         end
      end
      reg_req = 1'b0;
   endtask

   // PHY-initiated burst on an idle bus: first cycle is turnaround, nxt cycles are data.
   task automatic rx_burst(input int len);
      for (int i = 0; i < len; i++) begin
         ulpi_dir     = 1'b1;
         ulpi_nxt     = 1'($urandom_range(0, 1));
         ulpi_rx_data = 8'($urandom);
         if (i > 0 && ulpi_nxt == 1'b0) rx_q.push_back(ulpi_rx_data);
         tick();
         check("burst_tx_data", 32'(ulpi_tx_data), 32'd0);
      end
      ulpi_dir = 1'b0;
      ulpi_nxt = 1'b0;
      tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_tx_data"}, 32'(ulpi_tx_data), 32'd0);
      check({tag, "_stp"}, 32'(ulpi_stp), 32'd0);
      check({tag, "_ack"}, 32'(reg_ack), 32'd0);
      check({tag, "_err"}, 32'(reg_err), 32'd0);
      check({tag, "_rdata"}, 32'(reg_rdata), 32'd0);
      check({tag, "_rx_cmd"}, 32'(rx_cmd), 32'd0);
      check({tag, "_rx_cmd_valid"}, 32'(rx_cmd_valid), 32'd0);
   endtask

   initial begin : watchdog
      #300000;
      errors++;
      $display("FAIL watchdog: run exceeded its time budget");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int r;
      int na;
      rst          = 1'b0;
      ulpi_dir     = 1'b0;
      ulpi_nxt     = 1'b0;
      ulpi_rx_data = 8'h00;
      reg_req      = 1'b0;
      reg_we       = 1'b0;
      reg_addr     = 6'h00;
      reg_wdata    = 8'h00;
      repeat (3) tick();
      check_all_zero("reset");
      rst = 1'b1;
      tick();

      do_req(1'b1, 6'h04, 8'h55, 8'h00, 0, 0, 0);
      gap(2);
      do_req(1'b0, 6'h0A, 8'h00, 8'h3C, 0, 0, 0);
      gap(2);
      do_req(1'b1, 6'h12, 8'hA7, 8'h00, 1, 0, 0);
      gap(2);
      do_req(1'b0, 6'h2B, 8'h00, 8'hC3, MR - 1, 1, -1);
      gap(1);
      do_req(1'b0, 6'h21, 8'h00, 8'h99, MR, 1, -1);
      gap(1);
      do_req(1'b1, 6'h3F, 8'h00, 8'h00, MR - 1, 1, -1);
      gap(1);

      ulpi_dir     = 1'b1;
      ulpi_nxt     = 1'b0;
      ulpi_rx_data = 8'h4E;
      rx_q.push_back(8'h4E);
      tick();
      tick();
      ulpi_dir = 1'b0;
      tick();
      ulpi_dir     = 1'b1;
      ulpi_nxt     = 1'b1;
      ulpi_rx_data = 8'h77;
      tick();
      tick();
      ulpi_dir = 1'b0;
      ulpi_nxt = 1'b0;
      gap(2);

      reg_req   = 1'b1;
      reg_we    = 1'b1;
      reg_addr  = 6'h11;
      reg_wdata = 8'hA5;
      tick();
      check("rst_pre_cmd", 32'(ulpi_tx_data), 32'h91);
      ulpi_nxt = 1'b1;
      tick();
      ulpi_nxt = 1'b0;
      check("rst_pre_wdata", 32'(ulpi_tx_data), 32'hA5);
      #1 rst = 1'b0;
      #1;
      check_all_zero("rst_mid");
      reg_req = 1'b0;
      tick();
      tick();
      check_all_zero("rst_hold");
      rst = 1'b1;
      do_req(1'b1, 6'h11, 8'hA5, 8'h00, 0, 1, -1);
      gap(2);

      for (int i = 0; i < 40; i++) begin
         r  = $urandom_range(0, 9);
         na = (r < 5) ? 0 : r - 4;
         do_req(1'($urandom_range(0, 1)), 6'($urandom), 8'($urandom), 8'($urandom), na, 2, -1);
         gap($urandom_range(1, 3));
         if ($urandom_range(0, 3) == 0) rx_burst($urandom_range(1, 4));
      end

      gap(4);
      check("reg_queue_drained", 32'(reg_q.size()), 32'd0);
      check("rx_queue_drained", 32'(rx_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ulpi_reg_ctl.md
ULPI_REG_CTL -- requirements
Module: ulpi_reg_ctl

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 4: aborted attempts tolerated before a request completes with error.
REQ-002 SHALL have port clk  in  1  ULPI 60 MHz clock; all logic on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports ulpi_dir, ulpi_nxt  in  1 each  PHY direction / next.
REQ-005 SHALL have port ulpi_rx_data  in  8  data from PHY.
REQ-006 SHALL have port ulpi_tx_data  out  8  data to PHY, registered.
REQ-007 SHALL have port ulpi_stp  out  1  stop, registered.
REQ-008 SHALL have ports reg_req  in  1, reg_we  in  1, reg_addr  in  6, reg_wdata  in  8  register-access request.
REQ-009 SHALL have ports reg_ack  out  1, reg_err  out  1, reg_rdata  out  8  completion.
REQ-010 SHALL have ports rx_cmd  out  8, rx_cmd_valid  out  1  received RX CMD byte.

Function
REQ-011 SHALL implement states IDLE, CMD, WDATA, STP, RD_TURN, RD_DATA; ulpi_tx_data = 0 in all states except CMD and WDATA.
REQ-012 SHALL keep a registered copy dir_q of ulpi_dir; a turnaround cycle is any cycle with ulpi_dir != dir_q.
REQ-013 IDLE -> CMD when reg_req=1, ulpi_dir=0 and dir_q=0; SHALL latch reg_we, reg_addr and reg_wdata on this edge, leaving the retry count unchanged.
REQ-014 In CMD, ulpi_tx_data SHALL be {2'b10,addr} for a write and {2'b11,addr} for a read.
REQ-015 CMD with nxt=1, dir=0 SHALL go to WDATA for a write and to RD_TURN for a read; CMD SHALL hold while nxt=0, dir=0.
REQ-016 In WDATA, ulpi_tx_data SHALL be the latched wdata; nxt=1, dir=0 SHALL go to STP.
REQ-017 STP SHALL last exactly one cycle with ulpi_stp=1 and ulpi_tx_data=0, then go to IDLE with a reg_ack pulse, reg_err=0.
REQ-018 RD_TURN: dir=1, nxt=0 SHALL go to RD_DATA; dir=0 SHALL hold.
REQ-019 RD_DATA SHALL capture ulpi_rx_data into reg_rdata, pulse reg_ack with reg_err=0, and go to IDLE.
REQ-020 Abort: dir=1 in CMD or WDATA, or dir=1 with nxt=1 in RD_TURN, SHALL return the FSM to IDLE and increment the retry count, with ulpi_stp kept 0.
REQ-021 The abort that brings the retry count to MAX_RETRY SHALL pulse reg_ack with reg_err=1 and clear the count; otherwise the request SHALL be re-issued from IDLE automatically.
REQ-022 Retry count SHALL clear on every reg_ack.
REQ-023 reg_ack SHALL be a single-cycle pulse; reg_err and reg_rdata SHALL hold until the next reg_ack; reg_req SHALL be held by the requester until reg_ack.
REQ-024 Minimum latency: write from reg_req=1 to reg_ack=1 SHALL be 4 cycles; read SHALL be 4 cycles.
REQ-025 RX CMD: when dir=1, dir_q=1, nxt=0 and state != RD_DATA, SHALL register rx_cmd=ulpi_rx_data and pulse rx_cmd_valid next cycle.
REQ-026 nxt=1 with dir=1 (receive data) SHALL NOT update rx_cmd.
REQ-027 reg_req=0 in IDLE SHALL produce no bus activity; withdrawal of reg_req mid-transaction is illegal and unchecked.

Reset
REQ-028 rst=0 SHALL immediately force state IDLE, ulpi_tx_data=0, ulpi_stp=0, reg_ack=0, reg_err=0, reg_rdata=0, rx_cmd=0, rx_cmd_valid=0, retry count 0, dir_q=0.
REQ-029 Reset mid-transaction SHALL discard the request with no reg_ack; operation SHALL resume on the first edge after rst=1.

Verification
REQ-030 Write addr 0x04 data 0x55, PHY nxt=1 one cycle after each byte -> tx_data 0x84 then 0x55, stp=1 one cycle, reg_ack=1, reg_err=0.
REQ-031 Read addr 0x0A, PHY turns dir after nxt, drives 0x3C -> tx_data 0xCA, reg_rdata=0x3C, reg_ack=1, reg_err=0, rx_cmd_valid=0.
REQ-032 dir=1 during CMD of write once, then clean -> one abort, tx_data=0 while dir=1, command re-issued after dir=0 plus one turnaround cycle, reg_ack with reg_err=0.
REQ-033 dir forced 1 at every CMD, MAX_RETRY=4 -> fourth abort gives reg_ack=1, reg_err=1; the next request starts with retry count 0.
REQ-034 Idle bus, PHY dir=1, rx_data=0x4E, nxt=0 for two cycles -> rx_cmd=0x4E, rx_cmd_valid pulses; turnaround cycle ignored.
REQ-035 rst=0 asserted in WDATA -> all outputs 0 the same cycle, no reg_ack; a new write after release completes normally.
